aes_sub_bytes_seq: RTL and testbench
====================================

AES_SUB_BYTES_SEQ -- requirements
Module: aes_sub_bytes_seq

Interface
REQ-001 The block SHALL have parameter LANES, default 4, giving the number of bytes substituted per cycle; legal values are 1, 2, 4, 8 and 16.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port in_valid, input, 1 bit: a 128-bit state is offered on in_state.
REQ-005 The block SHALL have port in_ready, output, 1 bit: the block can accept a state.
REQ-006 The block SHALL have port in_state, input, 128 bits: the state to be substituted; byte 0 is in_state[127:120] and byte 15 is in_state[7:0] (FIPS-197 byte order).
REQ-007 The block SHALL have port out_valid, output, 1 bit: out_state holds a completed result.
REQ-008 The block SHALL have port out_ready, input, 1 bit: the downstream block accepts the result.
REQ-009 The block SHALL have port out_state, output, 128 bits: the SubBytes result, in the same byte order as in_state.
REQ-010 The block SHALL have port busy, output, 1 bit: high whenever the FSM is not in IDLE.

Function
REQ-011 The block SHALL implement the FIPS-197 forward S-box (the SubBytes transform) as an internal 256-entry constant table.
- For every x, sbox(inv_sbox(x)) = x.
REQ-012 The block SHALL implement an FSM with three states: IDLE, RUN and DONE.
REQ-013 In IDLE, in_ready SHALL be 1; in RUN and DONE, in_ready SHALL be 0.
REQ-014 A transfer SHALL occur on a clock edge where in_valid and in_ready are both 1. On that edge the block:
- captures in_state into an internal 128-bit buffer;
- clears the chunk counter to 0;
- enters RUN.
REQ-015 In RUN, on each edge the block SHALL:
- replace buffer bytes counter*LANES to counter*LANES+LANES-1 with their S-box images;
- then increment the counter.
REQ-016 The chunk counter SHALL be log2(16/LANES) bits wide, minimum 1 bit. When it reaches 16/LANES-1 it SHALL wrap to 0, and the FSM SHALL enter DONE on that same edge.
REQ-017 In DONE, out_valid SHALL be 1 and out_state SHALL equal the buffer.
- out_state SHALL hold stable until the handshake.
REQ-018 On an edge where out_valid and out_ready are both 1, the FSM SHALL return to IDLE.
- in_ready rises the following cycle.
- No new input is accepted on the same edge.
REQ-019 Latency SHALL be exactly 16/LANES cycles from the accepting edge to the edge after which out_valid is 1 (4 cycles for LANES=4, 16 for LANES=1).
REQ-020 Minimum issue interval SHALL be 16/LANES+2 cycles per block when out_ready is held at 1.
REQ-021 in_valid, in_state and out_ready values presented while in RUN SHALL have no effect.
REQ-022 out_state SHALL retain its last result after returning to IDLE; out_valid SHALL be 0 outside DONE.

Reset
REQ-023 While rst_n is 0, regardless of clk, the block SHALL force:
- FSM = IDLE, counter = 0, buffer = 0;
- out_valid = 0, busy = 0, in_ready = 1, out_state = 128'h0.
REQ-024 Reset asserted mid-RUN or mid-DONE SHALL abandon the block in progress; no partial result SHALL appear on out_valid after reset release.
REQ-025 After rst_n deasserts, the first transfer SHALL be possible on the first rising clk edge.

Verification
REQ-026 FIPS-197 vector, LANES=4, out_ready=1: in_state=193de3bea0f4e22b9ac68d2ae9f84808 -> out_state=d42711aee0bf98f1b8b45de51e415230 with out_valid high exactly 4 cycles after acceptance, for one cycle.
REQ-027 Table sweep: 16 blocks cover all bytes 00..ff (block k holds bytes 16k..16k+15), each checked against a reference S-box -> e.g. 00->63, 01->7c, 52->00, ff->16.
REQ-028 Backpressure: out_ready=0 for 10 cycles in DONE -> out_valid stays 1, out_state stable, in_ready=0, and a second in_valid is ignored until the handshake; after the handshake in_ready=1 the next cycle.
REQ-029 Reset mid-operation: assert rst_n=0 on the 2nd RUN cycle -> outputs immediately at their reset values; after release, the block accepts a new all-zero state -> out_state=6363...63 (16 bytes).
REQ-030 Parameter sweep: LANES=1, 2, 8 and 16 with the REQ-026 vector -> identical result, latency 16, 8, 2 and 1 cycles respectively.

Source files
------------

// File: rtl/aes_sub_bytes_seq.sv
// Sequential AES SubBytes engine: accepts one 128-bit state, substitutes
// LANES bytes per cycle through a constant FIPS-197 S-box table, then holds
// the result until the downstream side takes it.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | ready for a new state; out_state keeps the previous result
// RUN   | substituting chunk cnt_q of the buffer, one chunk per cycle
// DONE  | result valid on out_state, waiting for out_ready
module aes_sub_bytes_seq #(
  parameter int LANES = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state,
  output logic         busy
);

  localparam int NCHUNK = 16 / LANES;
  localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CW-1:0] LAST_CHUNK = CW'(NCHUNK - 1);

  // Entry x lives at bits [2047-8x -: 8], so the literal reads in table order.
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [127:0]    buf_q, buf_d;

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX[2047 - 8*int'(x) -: 8];
  endfunction

  // Next-state, chunk counter and buffer update.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    buf_d   = buf_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          buf_d   = in_state;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        // Byte j of the state sits at bits [127-8j -: 8] (byte 0 is the MSB).
        for (int i = 0; i < LANES; i++) begin
          buf_d[127 - 8*(int'(cnt_q)*LANES + i) -: 8] =
            sbox(buf_q[127 - 8*(int'(cnt_q)*LANES + i) -: 8]);
        end
        if (cnt_q == LAST_CHUNK) begin
          cnt_d   = '0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        // Returning to IDLE here means a new state can only be taken next edge.
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, counter and buffer registers with async active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      buf_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      buf_q   <= buf_d;
    end
  end

  // Handshake and status outputs decode directly from the state register.
  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    busy      = (state_q != IDLE);
    out_state = buf_q;
  end

endmodule

// File: tb/tb_aes_sub_bytes_seq.sv
// Self-checking bench for aes_sub_bytes_seq. Five instances (LANES = 4, 1,
// 2, 8, 16) share clock and reset; the reference S-box is derived from
// GF(2^8) inversion plus the AES affine map rather than a copied table.
module tb_aes_sub_bytes_seq;

  localparam logic [127:0] KAT_IN  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
  localparam logic [127:0] KAT_OUT = 128'hd42711aee0bf98f1b8b45de51e415230;

  function automatic int lanes_of(input int g);
    case (g)
      0:       return 4;
      1:       return 1;
      2:       return 2;
      3:       return 8;
      default: return 16;
    endcase
  endfunction

  logic             clk;
  logic             rst_n;
  logic [4:0]       in_valid, in_ready, out_valid, out_ready, busy;
  logic [4:0][127:0] in_state, out_state;

  int n_chk  = 0;
  int n_fail = 0;

  logic [7:0] sb_m [256];

  for (genvar g = 0; g < 5; g++) begin : g_dut
    aes_sub_bytes_seq #(.LANES(lanes_of(g))) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid[g]),
      .in_ready  (in_ready[g]),
      .in_state  (in_state[g]),
      .out_valid (out_valid[g]),
      .out_ready (out_ready[g]),
      .out_state (out_state[g]),
      .busy      (busy[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    logic       hi;
    a = a_in; b = b_in; p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      hi = a[7];
      a  = {a[6:0], 1'b0};
      if (hi) a = a ^ 8'h1b;
      b = {1'b0, b[7:1]};
    end
    return p;
  endfunction

  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    if (a == 8'h00) return 8'h00;
    for (int c = 1; c < 256; c++)
      if (gmul(a, 8'(c)) == 8'h01) return 8'(c);
    return 8'h00;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
    logic [7:0] r;
    r = v;
    for (int i = 0; i < n; i++) r = {r[6:0], r[7]};
    return r;
  endfunction

  function automatic logic [127:0] model_sub(input logic [127:0] s);
    logic [127:0] r;
    r = '0;
    for (int j = 0; j < 16; j++) r[127 - 8*j -: 8] = sb_m[s[127 - 8*j -: 8]];
    return r;
  endfunction

  // Offers st on instance g with out_ready held high; returns the result and
  // the number of cycles from the accepting edge until out_valid was seen.
  task automatic run_block(input int g, input logic [127:0] st,
                           output logic [127:0] res, output int lat);
    in_valid[g]  = 1'b1;
    in_state[g]  = st;
    out_ready[g] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid[g] = 1'b0;
    in_state[g] = ~st;
    lat = 0;
    while (!out_valid[g] && lat < 64) begin
      @(negedge clk);
      lat++;
    end
    if (lat >= 64) chk("run_timeout", 128'(out_valid[g]), 128'd1);
    res = out_state[g];
    @(negedge clk);
    chk("valid_one_cycle", 128'(out_valid[g]), 128'd0);
    chk("ready_after_done", 128'(in_ready[g]), 128'd1);
    chk("result_retained", out_state[g], res);
  endtask

  initial begin
    logic [127:0] res, st, st2, exp;
    int           lat, cyc;

    rst_n     = 1'b0;
    in_valid  = '0;
    out_ready = '0;
    in_state  = '0;

    for (int x = 0; x < 256; x++) sb_m[x] = 8'h63 ^ gf_inv(8'(x)) ^ rotl(gf_inv(8'(x)), 1)
                                          ^ rotl(gf_inv(8'(x)), 2) ^ rotl(gf_inv(8'(x)), 3)
                                          ^ rotl(gf_inv(8'(x)), 4);

    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int g = 0; g < 5; g++) begin
      chk("rst_in_ready", 128'(in_ready[g]), 128'd1);
      chk("rst_out_valid", 128'(out_valid[g]), 128'd0);
      chk("rst_busy", 128'(busy[g]), 128'd0);
      chk("rst_out_state", out_state[g], 128'h0);
    end

    // Release and offer the known-answer vector on the very next edge.
    rst_n = 1'b1;
    for (int g = 0; g < 5; g++) begin
      run_block(g, KAT_IN, res, lat);
      chk("kat_const", res, KAT_OUT);
      chk("kat_model", res, model_sub(KAT_IN));
      chk("kat_latency", 128'(lat), 128'(16 / lanes_of(g)));
    end

    // Every byte value 00..ff through the LANES=4 instance.
    for (int k = 0; k < 16; k++) begin
      for (int j = 0; j < 16; j++) st[127 - 8*j -: 8] = 8'(16*k + j);
      run_block(0, st, res, lat);
      chk("sweep", res, model_sub(st));
      if (k == 0) begin
        chk("sb_00", 128'(res[127:120]), 128'h63);
        chk("sb_01", 128'(res[119:112]), 128'h7c);
      end
      if (k == 5) chk("sb_52", 128'(res[111:104]), 128'h00);
      if (k == 15) chk("sb_ff", 128'(res[7:0]), 128'h16);
    end

    // Random states on every lane configuration.
    for (int g = 0; g < 5; g++) begin
      for (int n = 0; n < 8; n++) begin
        st = {$urandom, $urandom, $urandom, $urandom};
        run_block(g, st, res, lat);
        chk("random", res, model_sub(st));
        chk("random_latency", 128'(lat), 128'(16 / lanes_of(g)));
      end
    end

    // Backpressure: hold the result, ignore a competing input until handshake.
    st  = {$urandom, $urandom, $urandom, $urandom};
    st2 = {$urandom, $urandom, $urandom, $urandom};
    exp = model_sub(st);
    in_valid[0]  = 1'b1;
    in_state[0]  = st;
    out_ready[0] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    in_state[0] = st2;
    cyc = 0;
    while (!out_valid[0] && cyc < 64) begin
      @(negedge clk);
      cyc++;
    end
    chk("bp_reach_done", 128'(out_valid[0]), 128'd1);
    for (int n = 0; n < 10; n++) begin
      chk("bp_valid", 128'(out_valid[0]), 128'd1);
      chk("bp_state", out_state[0], exp);
      chk("bp_in_ready", 128'(in_ready[0]), 128'd0);
      @(negedge clk);
    end
    out_ready[0] = 1'b1;
    @(negedge clk);
    chk("bp_hs_in_ready", 128'(in_ready[0]), 128'd1);
    chk("bp_hs_busy", 128'(busy[0]), 128'd0);
    chk("bp_hs_valid", 128'(out_valid[0]), 128'd0);
    chk("bp_hs_retain", out_state[0], exp);
    @(negedge clk);
    in_valid[0] = 1'b0;
    chk("bp_second_accept", 128'(busy[0]), 128'd1);
    cyc = 0;
    while (!out_valid[0] && cyc < 64) begin
      @(negedge clk);
      cyc++;
    end
    chk("bp_second_result", out_state[0], model_sub(st2));
    @(negedge clk);

    // Reset during the second RUN cycle abandons the block.
    st = {$urandom, $urandom, $urandom, $urandom};
    in_valid[0] = 1'b1;
    in_state[0] = st;
    @(posedge clk);
    @(negedge clk);
    in_valid[0] = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_in_ready", 128'(in_ready[0]), 128'd1);
    chk("mid_rst_valid", 128'(out_valid[0]), 128'd0);
    chk("mid_rst_busy", 128'(busy[0]), 128'd0);
    chk("mid_rst_state", out_state[0], 128'h0);
    @(negedge clk);
    rst_n = 1'b1;
    chk("post_rst_valid", 128'(out_valid[0]), 128'd0);
    run_block(0, 128'h0, res, lat);
    chk("post_rst_zero", res, {16{8'h63}});
    chk("post_rst_latency", 128'(lat), 128'd4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
